// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the instruction fetch unit.
//  OPC_JAL      : RV opcode of JAL
//  RESET_PC_DEF : default first fetch address after reset
//  jal_imm()    : J-type immediate decode. It takes inst[31:12], because the
//                 immediate lives entirely in those bits.
package ysyx_22040088_pkg;

  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  // hi = inst[31:12]: hi[19]=inst[31], hi[18:9]=inst[30:21], hi[8]=inst[20],
  // hi[7:0]=inst[19:12].
  function automatic logic signed [20:0] jal_imm(input logic [19:0] hi);
    return {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_22040088_sync_fifo.sv
// Synchronous FIFO with flush and an occupancy count.
//  clk, rst     : clock, synchronous active-high reset (pointers/count only)
//  i_flush      : empties the FIFO; a same-cycle push is discarded
//  i_push       : write i_push_data (caller never pushes into a full FIFO
//                 unless it pops in the same cycle)
//  i_pop        : advance head (caller never pops an empty FIFO)
//  o_pop_data   : current head, read combinationally
//  o_count      : occupancy, 0..DEPTH
// DEPTH must be a power of 2, so the pointers wrap on their own. The count is
// the only source of full/empty information.
module ysyx_22040088_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/ysyx_22040088_ifu_fq.sv
// Instruction fetch unit with a decoupling fetch queue.
// Issues in-order pipelined ICache requests, tags each response with its PC
// through a PC-tag FIFO, predecodes JAL and feeds decode via valid/ready.
//  clk, rst                     : clock, synchronous active-high reset
//  redirect_valid, redirect_pc  : backend redirect; flushes the queue
//  ic_req, ic_addr              : ICache request (ic_addr = fetch PC)
//  ic_addr_ok                   : request accepted this cycle
//  ic_data_ok, ic_rdata         : one in-order response this cycle
//  out_valid/out_ready          : fetch-queue head handshake to decode
//  out_pc, out_inst, out_jal    : head PC, instruction, predecoded-JAL flag
//  fq_count                     : fetch-queue occupancy
module ysyx_22040088_ifu_fq
  import ysyx_22040088_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(RESET_PC_DEF),
  parameter int              FQ_DEPTH      = 4,
  parameter bit              JAL_PREDECODE = 1'b1,
  localparam int CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ic_req,
  output logic [XLEN-1:0] ic_addr,
  input  logic            ic_addr_ok,
  input  logic            ic_data_ok,
  input  logic [31:0]     ic_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_jal,
  output logic [CW-1:0]   fq_count
);

  localparam int FQW = XLEN + 33;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_kill_cnt;

  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_fq_count;
  logic [CW:0]     w_credit_used;
  logic [XLEN-1:0] w_tag_pc;
  logic [FQW-1:0]  w_fq_head;
  logic            w_resp;
  logic            w_is_jal;
  logic            w_keep;
  logic            w_jal_redir;
  logic            w_issue;
  logic            w_fq_pop;
  logic [CW-1:0]   w_out_after_resp;
  logic [20:0]     w_jal_imm;
  logic [XLEN-1:0] w_jal_target;

  // Outstanding requests are exactly the PC-tag FIFO occupancy.
  assign w_resp   = ic_data_ok && (w_outstanding != '0);
  assign w_is_jal = JAL_PREDECODE && (ic_rdata[6:0] == OPC_JAL);
  assign w_keep   = w_resp && (r_kill_cnt == '0) && !redirect_valid;
  assign w_jal_redir = w_keep && w_is_jal;

  // Killed requests still hold credit until their response returns, so a
  // response always finds room in the fetch queue.
  assign w_credit_used = {1'b0, w_fq_count} + {1'b0, w_outstanding};
  assign ic_req  = !rst && !redirect_valid && !w_jal_redir &&
                   (w_credit_used < (CW + 1)'(FQ_DEPTH));
  assign ic_addr = r_fetch_pc;
  assign w_issue = ic_req && ic_addr_ok;

  assign w_out_after_resp = w_outstanding - CW'(w_resp);
  assign w_jal_imm    = jal_imm(ic_rdata[31:12]);
  assign w_jal_target = w_tag_pc + {{(XLEN - 21){w_jal_imm[20]}}, w_jal_imm};

  // A redirect outranks the pop so the flushed head is never handed to decode.
  assign w_fq_pop = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_kill_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_kill_cnt <= w_out_after_resp;
    end else if (w_jal_redir) begin
      // Every request still in flight is a younger sequential fetch.
      r_fetch_pc <= w_jal_target;
      r_kill_cnt <= w_out_after_resp;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_resp && (r_kill_cnt != '0)) r_kill_cnt <= r_kill_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ic_data_ok && (w_outstanding == '0)));
      assert (r_kill_cnt <= w_outstanding);
    end
  end

  ysyx_22040088_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (1'b0),
    .i_push      (w_issue),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_resp),
    .o_pop_data  (w_tag_pc),
    .o_count     (w_outstanding)
  );

  ysyx_22040088_sync_fifo #(
    .WIDTH (FQW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_keep),
    .i_push_data ({w_tag_pc, ic_rdata, w_is_jal}),
    .i_pop       (w_fq_pop),
    .o_pop_data  (w_fq_head),
    .o_count     (w_fq_count)
  );

  assign fq_count  = w_fq_count;
  assign out_valid = (w_fq_count != '0);
  assign out_pc    = w_fq_head[FQW-1:33];
  assign out_inst  = w_fq_head[32:1];
  assign out_jal   = out_valid && w_fq_head[0];

endmodule
